// File: rtl/video_timing_gen_if.sv
// Video timing output bundle: pixel request side and DVI timing side.
// frame_cnt exists only when VTG_FRAME_COUNT_EN is defined.
interface video_timing_gen_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        frame_start;
  logic        video_de;
  logic        hsync;
  logic        vsync;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    output frame_start,
    output video_de,
    output hsync,
    output vsync
`ifdef VTG_FRAME_COUNT_EN
    ,
    output frame_cnt
`endif
  );

  modport slave (
    input pix_req,
    input pix_x,
    input pix_y,
    input frame_start,
    input video_de,
    input hsync,
    input vsync
`ifdef VTG_FRAME_COUNT_EN
    ,
    input frame_cnt
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, pixel request stage, DVI stage.
// Optional macro VTG_FRAME_COUNT_EN adds a 16-bit wrapping frame counter.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  video_timing_gen_if.master        vid_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] HS_B    = 12'(HS_BEG);
  localparam logic [11:0] HS_E    = 12'(HS_END);
  localparam logic [11:0] VS_B    = 12'(VS_BEG);
  localparam logic [11:0] VS_E    = 12'(VS_END);

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit range");
  end

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;

  logic        req_q,  req_d;
  logic [11:0] x_q,    x_d;
  logic [11:0] y_q,    y_d;
  logic        fs_q,   fs_d;
  logic        hs1_q,  hs1_d;
  logic        vs1_q,  vs1_d;

  logic        de_q;
  logic        hs_q,   hs_d;
  logic        vs_q,   vs_d;

  logic        h_wrap;
  logic        active;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? 12'd0 : h_q + 12'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end
  end

  always_comb begin
    active = (h_q < H_ACT) && (v_q < V_ACT);
    req_d  = active;
    x_d    = active ? h_q : 12'd0;
    y_d    = active ? v_q : 12'd0;
    fs_d   = (h_q == 12'd0) && (v_q == 12'd0);
    hs1_d  = (h_q >= HS_B) && (h_q < HS_E);
    vs1_d  = (v_q >= VS_B) && (v_q < VS_E);
  end

  // Region flags are tracked as "in region"; polarity is applied at the pins.
  always_comb begin
    hs_d = hs1_q ? SYNC_POL : ~SYNC_POL;
    vs_d = vs1_q ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
    end else begin
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
    end else begin
      de_q <= req_q;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fs_q ? fcnt_q + 16'd1 : fcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign vid_o.frame_cnt = fcnt_q;
`endif

  assign vid_o.pix_req     = req_q;
  assign vid_o.pix_x       = x_q;
  assign vid_o.pix_y       = y_q;
  assign vid_o.frame_start = fs_q;
  assign vid_o.video_de    = de_q;
  assign vid_o.hsync       = hs_q;
  assign vid_o.vsync       = vs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two polarities, small raster, random resets.
// Expected values come from a position-in-frame model of the raster.
module tb_video_timing_gen;

  localparam int HA = 16;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  video_timing_gen_if vif0 ();
  video_timing_gen_if vif1 ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .vid_o(vif0)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .vid_o(vif1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit req;
    int x;
    int y;
    bit fs;
    bit de;
    bit hs;
    bit vs;
    int fcnt;
  } exp_t;

  // n = number of clock edges since reset was released (0 while in reset)
  function automatic exp_t model(input int n);
    exp_t e;
    int   p, h, v;
    bit   act;
    e = '{default: 0};
    if (n >= 1) begin
      p     = (n - 1) % FT;
      h     = p % HT;
      v     = p / HT;
      act   = (h < HA) && (v < VA);
      e.req = act;
      e.x   = act ? h : 0;
      e.y   = act ? v : 0;
      e.fs  = (p == 0);
    end
    if (n >= 2) begin
      p      = (n - 2) % FT;
      h      = p % HT;
      v      = p / HT;
      e.de   = (h < HA) && (v < VA);
      e.hs   = (h >= HA + HF) && (h < HA + HF + HS);
      e.vs   = (v >= VA + VF) && (v < VA + VF + VS);
      e.fcnt = ((n - 2) / FT + 1) % 65536;
    end
    return e;
  endfunction

  task automatic cmp_all(input int n);
    exp_t e;
    e = model(n);
    check("pix_req",     vif0.pix_req,     e.req);
    check("pix_x",       vif0.pix_x,       e.x);
    check("pix_y",       vif0.pix_y,       e.y);
    check("frame_start", vif0.frame_start, e.fs);
    check("video_de",    vif0.video_de,    e.de);
    check("hsync_lo",    vif0.hsync,       e.hs ? 0 : 1);
    check("vsync_lo",    vif0.vsync,       e.vs ? 0 : 1);
    check("video_de_p1", vif1.video_de,    e.de);
    check("hsync_hi",    vif1.hsync,       e.hs ? 1 : 0);
    check("vsync_hi",    vif1.vsync,       e.vs ? 1 : 0);
`ifdef VTG_FRAME_COUNT_EN
    check("frame_cnt",   vif0.frame_cnt,   e.fcnt);
`endif
  endtask

  initial begin
    int n;
    int de_cnt, hs_cnt, vs_cnt, hs1_cnt;
    int fs_first, fs_second, de_rise, hs_fall, vs_fall;
    int rst_left;

    n = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs1_cnt = 0;
    fs_first = -1; fs_second = -1;
    de_rise = -1; hs_fall = -1; vs_fall = -1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_all(0);

    // Clean run of two frames from reset release
    rst = 1'b0;
    for (int c = 0; c < 2 * FT + 2; c++) begin
      @(posedge clk);
      #1;
      n++;
      cmp_all(n);
      if (n >= 2 && n <= FT + 1) begin
        if (vif0.video_de === 1'b1) de_cnt++;
        if (vif0.hsync === 1'b0) hs_cnt++;
        if (vif0.vsync === 1'b0) vs_cnt++;
        if (vif1.hsync === 1'b1) hs1_cnt++;
      end
      if (vif0.frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (de_rise < 0 && vif0.video_de === 1'b1) de_rise = n;
      if (hs_fall < 0 && vif0.hsync === 1'b0) hs_fall = n;
      if (vs_fall < 0 && vif0.vsync === 1'b0) vs_fall = n;
    end
    check("first_fs_cycle",  fs_first, 1);
    check("first_de_cycle",  de_rise, 2);
    check("fs_period",       fs_second - fs_first, FT);
    check("de_per_frame",    de_cnt, HA * VA);
    check("hsync_per_frame", hs_cnt, HS * VT);
    check("vsync_per_frame", vs_cnt, VS * HT);
    check("hsync_hi_frame",  hs1_cnt, HS * VT);
    check("hsync_offset",    hs_fall - de_rise, HA + HF);
    check("vsync_start",     vs_fall - de_rise, (VA + VF) * HT);

    // Mid-frame reset held three cycles
    repeat (HT * 3 + 7) begin
      @(posedge clk);
      #1;
      n++;
      cmp_all(n);
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      n = 0;
      cmp_all(n);
    end
    rst = 1'b0;

    // Free run with randomly placed resets
    rst_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      n = rst ? 0 : n + 1;
      cmp_all(n);
      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 3);
      end else begin
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter SYNC_POL, default 0: asserted level of hsync and vsync (0 = active-low).
REQ-006 clk  input  1: pixel clock, the single clock of the block.
REQ-007 rst  input  1: synchronous, active-high reset.
REQ-008 pix_req  output  1: pixel request to the pixel generator, one cycle ahead of video_de.
REQ-009 pix_x  output  12: column of the requested pixel.
REQ-010 pix_y  output  12: row of the requested pixel.
REQ-011 frame_start  output  1: single-cycle pulse with the pix_req for pixel (0,0).
REQ-012 video_de  output  1: data enable to the DVI transmitter.
REQ-013 hsync, vsync  output  1 each: sync outputs to the DVI transmitter, aligned with video_de.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (800 and 525 by default).
REQ-015 Horizontal counter h shall count 0..H_TOTAL-1 and wrap to 0, advancing every clk.
REQ-016 Vertical counter v shall advance only on h wrap, count 0..V_TOTAL-1, and wrap to 0 when h and v wrap together.
REQ-017 Active region: h < H_ACTIVE and v < V_ACTIVE.
REQ-018 Horizontal sync region: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
REQ-019 Vertical sync region: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines (h = 0..H_TOTAL-1).
REQ-020 Stage 1 (registered from h,v): pix_req = active; pix_x = h and pix_y = v when active, else 0; frame_start = (h==0 && v==0).
REQ-021 Stage 2 (registered): video_de = previous pix_req; hsync and vsync = previous sync regions, each driven to SYNC_POL when in region, else to ~SYNC_POL.
REQ-022 Latency: counter state -> pix_req is 1 cycle; pix_req -> video_de is exactly 1 cycle, so a 1-cycle registered RGB path aligns with video_de.
REQ-023 Counter widths shall be 12 bits; elaboration shall fail if H_TOTAL or V_TOTAL exceeds 4095.
REQ-024 No output shall glitch at counter wrap; all outputs come directly from flops.

Reset
REQ-025 While rst=1: h=0, v=0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, video_de=0, hsync=vsync=~SYNC_POL.
REQ-026 On the first clk after rst falls, counters start at (0,0): pix_req=1 and frame_start=1 on cycle 1, and video_de=1 on cycle 2.
REQ-027 Reset asserted mid-frame shall abort the frame at the next clk edge with no partial sync pulse extended, and timing restarts per REQ-026.

Configuration
REQ-028 Macro VTG_FRAME_COUNT_EN defined: adds output frame_cnt [15:0], reset to 0, incremented in the cycle after each frame_start, wrapping 65535->0.
REQ-029 Macro VTG_FRAME_COUNT_EN undefined: frame_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Release reset with default parameters -> pix_req=1, pix_x=0, pix_y=0, frame_start=1 at cycle 1; video_de=1 at cycle 2.
REQ-031 Run one line -> video_de high for 640 cycles per 800; hsync low for 96 cycles, with its falling edge 656 cycles after the video_de rising edge.
REQ-032 Run one frame -> 480x640 = 307200 video_de cycles; vsync low for 1600 cycles starting at line 490; frame_start period 420000 cycles.
REQ-033 Set SYNC_POL=1 -> hsync and vsync idle low and pulse high, with widths unchanged.
REQ-034 Assert rst at h=300, v=200 for 3 cycles -> all outputs reset immediately; after release, the sequence matches REQ-030.
REQ-035 VTG_FRAME_COUNT_EN defined, run 3 frames -> frame_cnt reads 1, 2 and 3 one cycle after the successive frame_start pulses.
